// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int         MEM_DEPTH = 16;
    localparam logic [7:0] INSN_NOP  = 8'h00;   // MOV A,A

    // Opcode prefixes (5 MSBs of an instruction). Low bits of each
    // prefix are don't-care in the CPU decoder and are shown as 0 here.
    localparam logic [4:0] OPC_MVI = 5'b10100;  // 1010z
    localparam logic [4:0] OPC_MOV = 5'b00000;  // 00zzz
    localparam logic [4:0] OPC_JMP = 5'b10010;  // 1001z

    // Build an instruction byte from a 5-bit opcode prefix and a 3-bit operand.
    function automatic logic [7:0] mk_insn(input logic [4:0] opc, input logic [2:0] arg);
        return {opc, arg};
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: asynchronous read, synchronous write, synchronous clear-all.
module prog_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    // Clear wins over write so a reset during a load never leaves a stray byte.
    always_ff @(posedge clk) begin
        if (clr)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    // Fetch path: CPU decodes the byte in the same cycle it presents the address.
    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory responder with a host byte-stream reload port.
// Holds the CPU in reset while a program is being written, then releases it.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout,
    input  logic              load_start,
    input  logic              load_end,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              cpu_reset,
    output logic              loading,
    output logic [ADDR_W:0]   load_count
);

    localparam int            DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wptr;
    logic              mem_clr;
    logic              mem_we;

    // State register; reset parks in RELEASE so the CPU sees one more reset cycle.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RELEASE;
        else
            state <= state_nx;
    end

    // Next state plus RAM clear/write strobes.
    always_comb begin
        state_nx = state;
        mem_clr  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            ST_RUN: begin
                if (load_start) begin
                    state_nx = ST_LOAD;
                    mem_clr  = 1'b1;
                end
            end
            ST_LOAD: begin
                // in_ready is 1 throughout LOAD, so any valid byte is accepted.
                mem_we = in_valid;
                if (load_end || (in_valid && load_count == LAST))
                    state_nx = ST_RELEASE;
            end
            ST_RELEASE: state_nx = ST_RUN;
            default:    state_nx = ST_RUN;
        endcase
    end

    // Write pointer and byte count; the count is held after a load for the host to read.
    always_ff @(posedge clk) begin
        if (reset || mem_clr) begin
            wptr       <= '0;
            load_count <= '0;
        end else if (mem_we) begin
            wptr       <= wptr + 1'b1;
            load_count <= load_count + 1'b1;
        end
    end

    // Outputs decode registered state only: no input reaches cpu_reset/in_ready.
    assign in_ready  = (state == ST_LOAD);
    assign loading   = (state == ST_LOAD);
    assign cpu_reset = (state != ST_RUN);

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .clr   (reset | mem_clr),
        .we    (mem_we & ~reset),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboard of expected memory images.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       load_start, load_end, in_valid;
    logic [7:0] in_data;
    logic       in_ready, cpu_reset, loading;
    logic [4:0] load_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [MEM_DEPTH];
    int         mwp;
    logic [7:0] exp_q [$];

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .dout       (dout),
        .load_start (load_start),
        .load_end   (load_end),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cpu_reset  (cpu_reset),
        .loading    (loading),
        .load_count (load_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_DEPTH; i++) model[i] = INSN_NOP;
        mwp = 0;
    endtask

    // A byte driven while the bench knows the block is in LOAD is written.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        model[mwp] = b;
        mwp++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        model_clear();
        tick();
        load_start = 1'b0;
        chk("load_entry_ready", in_ready, 1'b1);
        chk("load_entry_cpurst", cpu_reset, 1'b1);
    endtask

    // Push the expected image, then pop/compare while sweeping the fetch address.
    task automatic readback(input string tag);
        for (int i = 0; i < MEM_DEPTH; i++) exp_q.push_back(model[i]);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            logic [7:0] e;
            addr = 4'(i);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("%s_dout[%0d]", tag, i), dout, e);
        end
        addr = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; addr = '0; load_start = 0; load_end = 0;
        in_valid = 0; in_data = '0;
        model_clear();

        // Reset state
        tick(); tick();
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_loading", loading, 1'b0);
        chk("rst_load_count", load_count, 5'd0);
        chk("rst_dout", dout, 8'h00);
        reset = 1'b0;
        chk("rel_cpu_reset", cpu_reset, 1'b1);
        tick();
        chk("run_cpu_reset", cpu_reset, 1'b0);
        readback("empty");

        // Bytes offered in RUN are not consumed
        in_valid = 1'b1; in_data = 8'h66;
        chk("run_in_ready", in_ready, 1'b0);
        tick(); tick();
        in_valid = 1'b0;
        chk("run_no_count", load_count, 5'd0);

        // Three-byte program: MVI 5 at address 0 -> led=5 in system
        start_load();
        chk("load_cnt0", load_count, 5'd0);
        send(mk_insn(OPC_MVI, 3'd5));
        send(8'h30);
        send(8'h92);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("p3_release_ready", in_ready, 1'b0);
        chk("p3_release_cpurst", cpu_reset, 1'b1);
        chk("p3_count", load_count, 5'd3);
        tick();
        chk("p3_run_cpurst", cpu_reset, 1'b0);
        readback("p3");

        // Full 16-byte load with valid held into a 17th byte
        start_load();
        for (int i = 0; i < MEM_DEPTH; i++) begin
            chk("full_ready", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            model[i] = 8'h10 + 8'(i);
            tick();
        end
        in_data = 8'hFF;
        chk("full_ready_drop", in_ready, 1'b0);
        chk("full_count", load_count, 5'd16);
        chk("full_release_cpurst", cpu_reset, 1'b1);
        tick();
        chk("full_run_cpurst", cpu_reset, 1'b0);
        chk("full_run_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        chk("full_count_hold", load_count, 5'd16);
        readback("full");

        // load_end coincident with a valid byte
        start_load();
        send(8'h01);
        send(8'h02);
        in_valid = 1'b1; in_data = 8'h77; load_end = 1'b1;
        model[2] = 8'h77;
        tick();
        in_valid = 1'b0; load_end = 1'b0;
        chk("end_same_count", load_count, 5'd3);
        chk("end_same_ready", in_ready, 1'b0);
        tick();
        readback("endsame");

        // Bubbles and ignored load_start pulses
        start_load();
        load_start = 1'b1; tick(); load_start = 1'b0;
        send(8'h5A);
        tick();
        load_start = 1'b1; send(8'hC3); load_start = 1'b0;
        tick(); tick();
        chk("bubble_count_mid", load_count, 5'd2);
        chk("bubble_loading", loading, 1'b1);
        in_valid = 1'b1; in_data = 8'h3C; load_end = 1'b1;
        model[mwp] = 8'h3C; mwp++;
        tick();
        in_valid = 1'b0; load_end = 1'b0;
        chk("bubble_count", load_count, 5'd3);
        tick();
        readback("bubble");

        // One-byte reload over a three-byte program
        start_load();
        send(8'hEE);
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("one_count", load_count, 5'd1);
        tick();
        readback("one");

        // Zero-byte load
        start_load();
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("zero_count", load_count, 5'd0);
        tick();
        readback("zero");

        // Reset mid-load after five bytes
        start_load();
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i));
        chk("mid_count", load_count, 5'd5);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hBB;
        model_clear();
        tick();
        in_valid = 1'b0;
        chk("midrst_cpurst", cpu_reset, 1'b1);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_loading", loading, 1'b0);
        chk("midrst_count", load_count, 5'd0);
        readback("midrst");
        reset = 1'b0;
        chk("midrst_rel_cpurst", cpu_reset, 1'b1);
        tick();
        chk("midrst_run_cpurst", cpu_reset, 1'b0);
        chk("midrst_run_ready", in_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
